// File: rtl/axil_master.sv
// AXI4-Lite initiator: one single-beat read or write in flight, zero-wait slave gives rsp_valid 3 cycles after accept.
// Command side stalls (cmd_ready low) until the response is consumed; a per-transaction watchdog aborts with SLVERR.
module axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            resp;
    logic                  timeout;
  } rsp_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Counter holds the number of busy cycles already spent; saturates at the limit.
  localparam int              WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_vld_q, rsp_vld_d;
  rsp_t                    rsp_q, rsp_d;
  logic [WD_W-1:0]         wdog_q;

  logic cmd_fire, rsp_fire;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic aw_ok, w_ok;
  logic busy, expire;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_fire  = rsp_vld_q & rsp_ready;

  assign aw_fire = awvalid_q & m_axi_awready;
  assign w_fire  = wvalid_q  & m_axi_wready;
  assign b_fire  = bready_q  & m_axi_bvalid;
  assign ar_fire = arvalid_q & m_axi_arready;
  assign r_fire  = rready_q  & m_axi_rvalid;

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  assign aw_ok = ~awvalid_q | m_axi_awready;
  assign w_ok  = ~wvalid_q  | m_axi_wready;

  assign busy   = (state_q == WR_AW_W) || (state_q == WR_B) ||
                  (state_q == RD_AR)   || (state_q == RD_R);
  assign expire = WD_EN && busy && (wdog_q == WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completing handshakes are checked before expiry so a late handshake still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) state_d = cmd_write ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        if (aw_ok && w_ok) state_d = WR_B;
        else if (expire)   state_d = RSP;
      end
      WR_B: begin
        if (b_fire || expire) state_d = RSP;
      end
      RD_AR: begin
        if (ar_fire)     state_d = RD_R;
        else if (expire) state_d = RSP;
      end
      RD_R: begin
        if (r_fire || expire) state_d = RSP;
      end
      RSP: begin
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rsp_vld_d = rsp_vld_q;
    rsp_d     = rsp_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          arvalid_d = ~cmd_write;
          rsp_d     = '0;
        end
      end
      WR_AW_W: begin
        if (aw_ok && w_ok) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
        end else if (expire) begin
          awvalid_d     = 1'b0;
          wvalid_d      = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_d.resp    = RESP_SLVERR;
          rsp_d.timeout = 1'b1;
        end else begin
          if (aw_fire) awvalid_d = 1'b0;
          if (w_fire)  wvalid_d  = 1'b0;
        end
      end
      WR_B: begin
        if (b_fire) begin
          bready_d   = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_d.resp = m_axi_bresp;
        end else if (expire) begin
          bready_d      = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_d.resp    = RESP_SLVERR;
          rsp_d.timeout = 1'b1;
        end
      end
      RD_AR: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expire) begin
          arvalid_d     = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_d.resp    = RESP_SLVERR;
          rsp_d.timeout = 1'b1;
        end
      end
      RD_R: begin
        if (r_fire) begin
          rready_d    = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_d.rdata = m_axi_rdata;
          rsp_d.resp  = m_axi_rresp;
        end else if (expire) begin
          rready_d      = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_d.resp    = RESP_SLVERR;
          rsp_d.timeout = 1'b1;
        end
      end
      RSP: begin
        if (rsp_fire) rsp_vld_d = 1'b0;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rsp_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (cmd_fire) begin
      wdog_q <= '0;
    end else if (WD_EN && busy && (wdog_q != WD_LIMIT)) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  assign rsp_valid   = rsp_vld_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_timeout = rsp_q.timeout;

  // Pending valids hold with a stable payload unless the watchdog aborts.
  ap_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axi_awvalid && !m_axi_awready && !expire) |=> (m_axi_awvalid && $stable(m_axi_awaddr)));
  ap_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axi_wvalid && !m_axi_wready && !expire) |=> (m_axi_wvalid && $stable(m_axi_wdata)));
  ap_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axi_arvalid && !m_axi_arready && !expire) |=> (m_axi_arvalid && $stable(m_axi_araddr)));
  ap_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_resp)));

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a cycle-programmable AXI4-Lite slave model (watchdog limit 8).
module tb_axil_master;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model: decides at each falling edge what fires on the next rising edge.
  int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          b_cnt = 0;
  logic [31:0] mem [0:15];
  bit          have_aw, have_w, have_ar, b_fire, r_fire;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[5] = 32'hA5A5_0014;
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
    {have_aw, have_w, have_ar, b_fire, r_fire} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        {have_aw, have_w, have_ar, b_fire, r_fire} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
      end else begin
        if (b_fire) begin
          m_axi_bvalid = 1'b0; b_cnt++; have_aw = 1'b0; have_w = 1'b0;
          if (m_axi_bresp == 2'b00)
            for (int i = 0; i < 4; i++)
              if (s_wstrb[i]) mem[s_awaddr[5:2]][i*8 +: 8] = s_wdata[i*8 +: 8];
        end
        if (r_fire) begin m_axi_rvalid = 1'b0; have_ar = 1'b0; end
        if (have_aw && have_w && !m_axi_bvalid) begin
          if (b_wait >= b_lat) begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; b_wait = 0; end
          else b_wait++;
        end
        if (have_ar && !m_axi_rvalid) begin
          if (r_wait >= r_lat) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = mem[s_araddr[5:2]]; m_axi_rresp = 2'b00; r_wait = 0;
          end else r_wait++;
        end
        m_axi_awready = 1'b0;
        if (m_axi_awvalid && !have_aw) begin
          if (aw_wait >= aw_lat) begin m_axi_awready = 1'b1; have_aw = 1'b1; s_awaddr = m_axi_awaddr; aw_wait = 0; end
          else aw_wait++;
        end else aw_wait = 0;
        m_axi_wready = 1'b0;
        if (m_axi_wvalid && !have_w) begin
          if (w_wait >= w_lat) begin
            m_axi_wready = 1'b1; have_w = 1'b1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; w_wait = 0;
          end else w_wait++;
        end else w_wait = 0;
        m_axi_arready = 1'b0;
        if (m_axi_arvalid && !have_ar) begin
          if (ar_wait >= ar_lat) begin m_axi_arready = 1'b1; have_ar = 1'b1; s_araddr = m_axi_araddr; ar_wait = 0; end
          else ar_wait++;
        end else ar_wait = 0;
        b_fire = m_axi_bvalid && m_axi_bready;
        r_fire = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  // Returns at the falling edge of the first cycle after the command is accepted.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_at_issue", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
  endtask

  task automatic expect_rsp(input string tag, input int lat, input logic [31:0] rd,
                            input logic [1:0] rr, input logic to);
    int k;
    wait_rsp(k);
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_resp"}, rsp_resp, rr);
    chk({tag, "_timeout"}, rsp_timeout, to);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, rsp_valid, 1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, b0, extra;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", rsp_resp, 2'b00);
    chk("rst_awaddr", m_axi_awaddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write then readback.
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("wr0_awvalid", m_axi_awvalid, 1'b1);
    chk("wr0_wvalid", m_axi_wvalid, 1'b1);
    chk("wr0_awaddr", m_axi_awaddr, 32'h10);
    chk("wr0_wdata", m_axi_wdata, 32'hDEAD_BEEF);
    chk("wr0_cmd_ready_busy", cmd_ready, 1'b0);
    expect_rsp("wr0", 2, 32'h0, 2'b00, 1'b0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    expect_rsp("rd0", 2, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // awready three cycles late, wready immediate, partial strobe.
    aw_lat = 3; b0 = b_cnt;
    send(1'b1, 32'h0000_0018, 32'h1234_5678, 4'h3);
    chk("wr1_n1_awvalid", m_axi_awvalid, 1'b1);
    chk("wr1_n1_wvalid", m_axi_wvalid, 1'b1);
    chk("wr1_n1_wstrb", m_axi_wstrb, 4'h3);
    @(negedge clk);
    chk("wr1_n2_wvalid", m_axi_wvalid, 1'b0);
    chk("wr1_n2_awvalid", m_axi_awvalid, 1'b1);
    @(negedge clk);
    chk("wr1_n3_awvalid", m_axi_awvalid, 1'b1);
    chk("wr1_n3_awaddr", m_axi_awaddr, 32'h18);
    chk("wr1_n3_bready", m_axi_bready, 1'b0);
    @(negedge clk);
    chk("wr1_n4_awvalid", m_axi_awvalid, 1'b1);
    expect_rsp("wr1", 2, 32'h0, 2'b00, 1'b0);
    extra = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) extra++; end
    chk("wr1_extra_rsp", extra, 0);
    chk("wr1_b_count", b_cnt - b0, 1);
    aw_lat = 0;
    send(1'b0, 32'h0000_0018, 32'h0, 4'h0);
    expect_rsp("rd1", 2, 32'h0000_5678, 2'b00, 1'b0);

    // Slow R channel, response held off by rsp_ready for four cycles.
    r_lat = 5;
    send(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    chk("rd2_arvalid", m_axi_arvalid, 1'b1);
    chk("rd2_araddr", m_axi_araddr, 32'h14);
    wait_rsp(k);
    chk("rd2_latency", k, 7);
    for (int i = 0; i < 4; i++) begin
      chk("rd2_hold_valid", rsp_valid, 1'b1);
      chk("rd2_hold_rdata", rsp_rdata, 32'hA5A5_0014);
      chk("rd2_hold_resp", rsp_resp, 2'b00);
      chk("rd2_hold_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    expect_rsp("rd2", 0, 32'hA5A5_0014, 2'b00, 1'b0);
    r_lat = 0;

    // Slave never grants AR: watchdog abort, then a normal read.
    ar_lat = 1000;
    send(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    wait_rsp(k);
    chk("to_latency", k, TO + 1);
    chk("to_arvalid", m_axi_arvalid, 1'b0);
    chk("to_rready", m_axi_rready, 1'b0);
    expect_rsp("to", 0, 32'h0, 2'b10, 1'b1);
    ar_lat = 0;
    send(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    expect_rsp("after_to", 2, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // DECERR passes through.
    bresp_cfg = 2'b11;
    send(1'b1, 32'h0000_0024, 32'h0000_0001, 4'hF);
    expect_rsp("decerr", 2, 32'h0, 2'b11, 1'b0);
    bresp_cfg = 2'b00;

    // Reset while waiting on B.
    b_lat = 20;
    send(1'b1, 32'h0000_0028, 32'h55AA_55AA, 4'hF);
    @(negedge clk);
    chk("rst_mid_bready_before", m_axi_bready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bready", m_axi_bready, 1'b0);
    chk("rst_mid_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_mid_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_mid_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_mid_rready", m_axi_rready, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b_lat = 0;
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    extra = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) extra++; end
    chk("rst_mid_no_rsp", extra, 0);
    send(1'b1, 32'h0000_0028, 32'h55AA_55AA, 4'hF);
    expect_rsp("post_rst_wr", 2, 32'h0, 2'b00, 1'b0);
    send(1'b0, 32'h0000_0028, 32'h0, 4'h0);
    expect_rsp("post_rst_rd", 2, 32'h55AA_55AA, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
